// File: rtl/main_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the asynchronous main RAM.
interface main_ram_arbiter_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 20
);
    // Requester side
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [WIDTH-1:0]      wdata0;
    logic [WIDTH-1:0]      wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [WIDTH-1:0]      rdata0;
    logic [WIDTH-1:0]      rdata1;
    logic                  busy;
    // RAM side
    logic                  ram_cs_n;
    logic                  ram_oe_n;
    logic                  ram_w_n;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]      ram_wdata;
    logic [WIDTH-1:0]      ram_rdata;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output ack0, ack1, rdata0, rdata1, busy,
               ram_cs_n, ram_oe_n, ram_w_n, ram_addr, ram_wdata
    );

    // Requester view
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, busy
    );

    // RAM device view
    modport ram (
        input  ram_cs_n, ram_oe_n, ram_w_n, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/main_ram_arbiter.sv
// Round-robin arbiter sharing the asynchronous main RAM between the CPU (port 0)
// and DMA/video (port 1), sequencing _cs/_oe/_w with fixed setup/pulse/hold cycles.
module main_ram_arbiter #(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 1
) (
    input  logic              clk,
    input  logic              _reset,
    main_ram_arbiter_if.slave bus
);
    localparam int CNT_MAX = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WSTROBE,
        WHOLD,
        RWAIT,
        RDONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata0_q, rdata0_d;
    logic [WIDTH-1:0]      rdata1_q, rdata1_d;
    logic                  cs_n_q, cs_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  w_n_q, w_n_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  busy_q, busy_d;
    logic                  grant_port;

    // Next-state: arbitration in IDLE, strobe sequencing, read-data capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        grant_port = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_port = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
                    port_d     = grant_port;
                    ptr_d      = ~grant_port;
                    we_d       = grant_port ? bus.we1 : bus.we0;
                    addr_d     = grant_port ? bus.addr1 : bus.addr0;
                    wdata_d    = grant_port ? bus.wdata1 : bus.wdata0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (we_q) begin
                    state_d = WSTROBE;
                    cnt_d   = CNT_W'(WRITE_PULSE - 1);
                end else begin
                    state_d = RWAIT;
                    cnt_d   = CNT_W'(READ_WAIT - 1);
                end
            end
            WSTROBE: begin
                if (cnt_q == '0) begin
                    state_d = WHOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RWAIT: begin
                if (cnt_q == '0) begin
                    state_d = RDONE;
                    if (port_q) begin
                        rdata1_d = bus.ram_rdata;
                    end else begin
                        rdata0_d = bus.ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WHOLD:   state_d = IDLE;
            RDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a register
    always_comb begin
        cs_n_d = (state_d == IDLE) || (state_d == RDONE);
        oe_n_d = !(((state_d == SETUP) && !we_d) || (state_d == RWAIT));
        w_n_d  = (state_d != WSTROBE);
        ack0_d = ((state_d == WHOLD) || (state_d == RDONE)) && !port_d;
        ack1_d = ((state_d == WHOLD) || (state_d == RDONE)) && port_d;
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cs_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            w_n_q    <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            port_q   <= port_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cs_n_q   <= cs_n_d;
            oe_n_q   <= oe_n_d;
            w_n_q    <= w_n_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = busy_q;
    assign bus.ram_cs_n  = cs_n_q;
    assign bus.ram_oe_n  = oe_n_q;
    assign bus.ram_w_n   = w_n_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
endmodule

// File: tb/tb_main_ram_arbiter.sv
// Self-checking bench: default-parameter arbiter checked every cycle against an
// access-timeline model, plus a READ_WAIT=4/WRITE_PULSE=3 instance checked directly.
module tb_main_ram_arbiter;
    localparam int W   = 8;
    localparam int AW  = 20;
    localparam int RW0 = 2;
    localparam int WP0 = 1;
    localparam int RW1 = 4;
    localparam int WP1 = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    main_ram_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) b0 ();
    main_ram_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) b1 ();

    main_ram_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_WAIT(RW0), .WRITE_PULSE(WP0))
        dut0 (.clk(clk), ._reset(rst_n), .bus(b0));
    main_ram_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_WAIT(RW1), .WRITE_PULSE(WP1))
        dut1 (.clk(clk), ._reset(rst_n), .bus(b1));

    // Asynchronous RAM devices: write on falling _w, combinational read
    logic [W-1:0] ram0 [64];
    logic [W-1:0] ram1 [64];
    always @(negedge b0.ram_w_n) if (!b0.ram_cs_n) ram0[b0.ram_addr[5:0]] <= b0.ram_wdata;
    always @(negedge b1.ram_w_n) if (!b1.ram_cs_n) ram1[b1.ram_addr[5:0]] <= b1.ram_wdata;
    assign b0.ram_rdata = (!b0.ram_cs_n && !b0.ram_oe_n) ? ram0[b0.ram_addr[5:0]] : '0;
    assign b1.ram_rdata = (!b1.ram_cs_n && !b1.ram_oe_n) ? ram1[b1.ram_addr[5:0]] : '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model of dut0 ----------------
    // An access is a timeline of L = pulse+2 busy cycles counted from the grant.
    bit           m_valid = 0;
    bit           m_active;
    int           m_k, m_L;
    bit           m_we, m_p, m_ptr;
    logic [AW-1:0] m_addr;
    logic [W-1:0] m_wdata;
    logic [AW-1:0] e_addr;
    logic [W-1:0] e_wdata;
    logic [W-1:0] e_rd [2];
    logic [W-1:0] mmem [64];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid  = 1;
            m_active = 0;
            m_k      = 0;
            m_ptr    = 0;
            e_addr   = '0;
            e_wdata  = '0;
            e_rd[0]  = '0;
            e_rd[1]  = '0;
        end else if (m_valid) begin
            if (m_active) begin
                m_k++;
                if (m_k > m_L) m_active = 0;
                else if (m_we && m_k == 2) mmem[m_addr[5:0]] = m_wdata;
                else if (!m_we && m_k == m_L) e_rd[m_p] = mmem[m_addr[5:0]];
            end else if (b0.req0 || b0.req1) begin
                m_p      = (b0.req0 && b0.req1) ? m_ptr : b0.req1;
                m_ptr    = !m_p;
                m_we     = m_p ? b0.we1 : b0.we0;
                m_addr   = m_p ? b0.addr1 : b0.addr0;
                m_wdata  = m_p ? b0.wdata1 : b0.wdata0;
                e_addr   = m_addr;
                e_wdata  = m_wdata;
                m_L      = m_we ? WP0 + 2 : RW0 + 2;
                m_k      = 1;
                m_active = 1;
            end
        end
    end

    // Every-cycle comparison of dut0 against the model
    always @(negedge clk) begin
        if (m_valid) begin
            logic x_cs, x_oe, x_w, x_ack;
            x_ack = m_active && (m_k == m_L);
            x_cs  = !(m_active && !(!m_we && m_k == m_L));
            x_oe  = !(m_active && !m_we && m_k <= RW0 + 1);
            x_w   = !(m_active && m_we && m_k >= 2 && m_k <= WP0 + 1);
            check("cs_n", b0.ram_cs_n, x_cs);
            check("oe_n", b0.ram_oe_n, x_oe);
            check("w_n", b0.ram_w_n, x_w);
            check("ack0", b0.ack0, x_ack && !m_p);
            check("ack1", b0.ack1, x_ack && m_p);
            check("busy", b0.busy, m_active);
            check("ram_addr", b0.ram_addr, e_addr);
            check("ram_wdata", b0.ram_wdata, e_wdata);
            check("rdata0", b0.rdata0, e_rd[0]);
            check("rdata1", b0.rdata1, e_rd[1]);
            check("oe_w_excl", !b0.ram_oe_n && !b0.ram_w_n, 1'b0);
        end
    end

    // Strobe pulse-length monitors
    int wlo0 = 0, olo0 = 0, last_w0 = 0, last_o0 = 0;
    int wlo1 = 0, olo1 = 0, last_w1 = 0, last_o1 = 0;
    always @(negedge clk) begin
        if (!b0.ram_w_n) wlo0++; else if (wlo0 != 0) begin last_w0 = wlo0; wlo0 = 0; end
        if (!b0.ram_oe_n) olo0++; else if (olo0 != 0) begin last_o0 = olo0; olo0 = 0; end
        if (!b1.ram_w_n) wlo1++; else if (wlo1 != 0) begin last_w1 = wlo1; wlo1 = 0; end
        if (!b1.ram_oe_n) olo1++; else if (olo1 != 0) begin last_o1 = olo1; olo1 = 0; end
    end

    function automatic logic ackof(input int d, input int p);
        if (d == 0) return p ? b0.ack1 : b0.ack0;
        return p ? b1.ack1 : b1.ack0;
    endfunction

    task automatic set_req(input int d, input int p, input logic r, input logic we,
                           input logic [AW-1:0] a, input logic [W-1:0] dt);
        if (d == 0 && p == 0) begin b0.req0 = r; b0.we0 = we; b0.addr0 = a; b0.wdata0 = dt; end
        if (d == 0 && p == 1) begin b0.req1 = r; b0.we1 = we; b0.addr1 = a; b0.wdata1 = dt; end
        if (d == 1 && p == 0) begin b1.req0 = r; b1.we0 = we; b1.addr0 = a; b1.wdata0 = dt; end
        if (d == 1 && p == 1) begin b1.req1 = r; b1.we1 = we; b1.addr1 = a; b1.wdata1 = dt; end
    endtask

    // Bounded wait for a port's ack; latency is -1 when the bound expires
    task automatic wait_ack(input int d, input int p, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ackof(d, p)) begin
                lat = cyc - t0;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int lat, t0, nacks, found;
        int order [4];
        int wc [2];
        bit pend [2];

        for (int i = 0; i < 64; i++) begin
            ram0[i] = '0; ram1[i] = '0; mmem[i] = '0;
        end
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) set_req(d, p, 0, 0, '0, '0);

        // Reset held 3 cycles with a pending port-0 write
        set_req(0, 0, 1, 1, 20'h00010, 8'hA5);
        repeat (3) @(negedge clk);
        check("rst_cs_n", b0.ram_cs_n, 1);
        check("rst_oe_n", b0.ram_oe_n, 1);
        check("rst_w_n", b0.ram_w_n, 1);
        check("rst_acks", {b0.ack0, b0.ack1}, 2'b00);
        check("rst_busy", b0.busy, 0);
        check("rst_rdata", {b0.rdata0, b0.rdata1}, 16'h0000);
        rst_n = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("post_rst_start_busy", b0.busy, 1);
        wait_ack(0, 0, t0, lat);
        check("write_latency", lat, WP0 + 2);
        set_req(0, 0, 0, 1, 20'h00010, 8'hA5);
        repeat (2) @(negedge clk);
        check("write_pulse_len", last_w0, 1);
        check("ram_after_write", ram0[16], 8'hA5);

        // Single read by port 1
        set_req(0, 1, 1, 0, 20'h00010, 8'h00);
        t0 = cyc;
        wait_ack(0, 1, t0, lat);
        check("read_latency", lat, RW0 + 2);
        check("read_rdata1", b0.rdata1, 8'hA5);
        set_req(0, 1, 0, 0, 20'h00010, 8'h00);
        repeat (3) @(negedge clk);
        check("read_oe_len", last_o0, 3);
        check("rdata1_held", b0.rdata1, 8'hA5);

        // Contention: both held, re-requesting after each ack
        set_req(0, 0, 1, 1, 20'h5, 8'h11);
        set_req(0, 1, 1, 1, 20'h6, 8'h22);
        nacks = 0;
        for (int i = 0; i < 60 && nacks < 4; i++) begin
            @(negedge clk);
            if (b0.ack0) begin order[nacks] = 0; nacks++; end
            else if (b0.ack1) begin order[nacks] = 1; nacks++; end
        end
        set_req(0, 0, 0, 1, 20'h5, 8'h11);
        set_req(0, 1, 0, 1, 20'h6, 8'h22);
        check("contention_count", nacks, 4);
        for (int i = 0; i < 4; i++) check("grant_order", order[i], i % 2);
        repeat (3) @(negedge clk);
        check("ram_5", ram0[5], 8'h11);
        check("ram_6", ram0[6], 8'h22);

        // Randomized traffic on both ports
        pend[0] = 0; pend[1] = 0; wc[0] = 0; wc[1] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    wc[p]++;
                    if (ackof(0, p)) begin
                        check("rand_wait_bound", wc[p] > 2 * (RW0 + 3), 0);
                        pend[p] = 0;
                    end
                end
                if (!pend[p]) begin
                    if ($urandom_range(2) == 0) begin
                        set_req(0, p, 1, 1'($urandom_range(1)), AW'($urandom_range(63)),
                                W'($urandom_range(255)));
                        pend[p] = 1;
                        wc[p]   = 0;
                    end else begin
                        if (p == 0) b0.req0 = 0; else b0.req1 = 0;
                    end
                end
            end
        end
        b0.req0 = 0;
        b0.req1 = 0;
        repeat (12) @(negedge clk);

        // Reset asserted during the write strobe
        set_req(0, 1, 1, 1, 20'h20, 8'h3C);
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(negedge clk);
            if (!b0.ram_w_n) found = 1;
        end
        check("wstrobe_reached", found, 1);
        rst_n = 1'b0;
        b0.req1 = 0;
        @(negedge clk);
        check("midrst_w_n", b0.ram_w_n, 1);
        check("midrst_cs_n", b0.ram_cs_n, 1);
        check("midrst_busy", b0.busy, 0);
        check("midrst_ack1", b0.ack1, 0);
        check("midrst_ram", ram0[32], 8'h3C);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_late_ack", b0.ack1, 0);

        // Parameter sweep instance: READ_WAIT=4, WRITE_PULSE=3
        set_req(1, 0, 1, 1, 20'h7, 8'h5A);
        t0 = cyc;
        wait_ack(1, 0, t0, lat);
        check("p_write_latency", lat, 5);
        set_req(1, 0, 0, 1, 20'h7, 8'h5A);
        repeat (3) @(negedge clk);
        check("p_w_len", last_w1, 3);
        check("p_ram", ram1[7], 8'h5A);
        set_req(1, 0, 1, 0, 20'h7, 8'h00);
        t0 = cyc;
        wait_ack(1, 0, t0, lat);
        check("p_read_latency", lat, 6);
        check("p_rdata0", b1.rdata0, 8'h5A);
        set_req(1, 0, 0, 0, 20'h7, 8'h00);
        repeat (3) @(negedge clk);
        check("p_oe_len", last_o1, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/main_ram_arbiter.md
Name: main_ram_arbiter

Overview:
- Synchronous controller that shares the asynchronous main RAM (active-low _cs/_oe/_w, 20-bit address, WIDTH-bit data) between two requesters (port 0: CPU, port 1: DMA/video).
- Arbitrates round-robin and sequences the RAM strobes with fixed setup, pulse and hold cycles.
- Returns a one-cycle acknowledge with registered read data.
- Sits between the core bus logic and the main RAM model/device.

Parameters:
- WIDTH, 8: data word width.
- ADDR_WIDTH, 20: RAM address width.
- READ_WAIT, 2: cycles _oe held low after setup before read data is captured (≥1).
- WRITE_PULSE, 1: cycles _w held low (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- _reset  input  1  synchronous active-low reset.
- req0 / req1  input  1  access request. Held high with stable we/addr/wdata until ack.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  ADDR_WIDTH  word address.
- wdata0 / wdata1  input  WIDTH  write data.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata0 / rdata1  output  WIDTH  read data. Valid in the ack cycle and held until that port's next read completes.
- busy  output  1  high whenever state != IDLE.
- ram_cs_n  output  1  to RAM _cs.
- ram_oe_n  output  1  to RAM _oe.
- ram_w_n  output  1  to RAM _w. The RAM writes on its falling edge.
- ram_addr  output  ADDR_WIDTH  to RAM addr.
- ram_wdata  output  WIDTH  to RAM data_in.
- ram_rdata  input  WIDTH  from RAM data_out.

Behaviour:
- All outputs are registered. Reset (_reset low at a rising edge) forces:
  - state IDLE;
  - ram_cs_n, ram_oe_n, ram_w_n = 1;
  - ack0, ack1 = 0; busy = 0;
  - ram_addr, ram_wdata, rdata0, rdata1 = 0;
  - priority pointer = port 0.
- IDLE:
  - Strobes inactive.
  - If any req is high, pick a winner, latch we/addr/wdata into ram_addr/ram_wdata and an internal op flag, and go to SETUP.
- Arbitration:
  - Only one request → it wins.
  - Both requesting → the port the pointer names wins.
  - Pointer moves to the other port on each grant; it is unchanged when no grant occurs.
- SETUP (1 cycle):
  - ram_cs_n = 0 and address valid.
  - Read: ram_oe_n = 0, go to RWAIT.
  - Write: ram_oe_n = 1, ram_w_n = 1, go to WSTROBE.
- WSTROBE (WRITE_PULSE cycles):
  - ram_cs_n = 0, ram_w_n = 0.
  - Address and data stay stable throughout, including at the falling edge of _w.
  - Then go to WHOLD.
- WHOLD (1 cycle): ram_cs_n = 0, ram_w_n = 1, ack of the winner = 1. Next state is IDLE.
- RWAIT (READ_WAIT cycles):
  - ram_cs_n = 0, ram_oe_n = 0.
  - At the rising edge ending the last RWAIT cycle, register ram_rdata into the winner's rdata.
  - Then go to RDONE.
- RDONE (1 cycle): strobes inactive, winner's ack = 1. Next state is IDLE.
- Latency (req high in IDLE cycle T):
  - Read: ack in cycle T+2+READ_WAIT (T+4 at default).
  - Write: ack in cycle T+2+WRITE_PULSE (T+3 at default).
  - At least one IDLE cycle separates accesses. Default throughput is 1 access per 5 (read) or 4 (write) cycles.
- Handshake:
  - The requester samples ack at the edge ending the ack cycle and drops req or presents a new request there.
  - req still high in the following IDLE cycle is a new request.
  - req dropped before ack is a protocol violation. The access still completes and ack still pulses.
- The loser's request is untouched and is served after the current access. There is no starvation: the pointer guarantees alternation under continuous contention.
- ram_addr and ram_wdata hold their last values while IDLE. ram_w_n and ram_oe_n are never low simultaneously.
- Reset mid-operation: strobes return high at the reset edge and no ack is issued.
  - A write whose ram_w_n had already fallen has been performed.
  - A write still in SETUP has not.
- The counter for WSTROBE/RWAIT is sized to max(READ_WAIT, WRITE_PULSE) and reloads on every entry.

Test Plan:
- Reset: hold _reset low 3 cycles with req0=1 → all strobes 1, ack0/ack1 0, busy 0, rdata 0. After release, the port-0 access starts the next cycle.
- Single write: port 0 writes 0xA5 to addr 0x00010 → ram_w_n low exactly 1 cycle with addr/data stable. ack0 at T+3. The RAM location holds 0xA5.
- Single read: port 1 reads addr 0x00010 after the above write → ram_oe_n low 3 cycles (SETUP + 2 RWAIT). ack1 at T+4 with rdata1 = 0xA5. rdata1 held afterward.
- Contention: req0 and req1 raised in the same cycle with both held (port 0 writes 0x11 @0x5, port 1 writes 0x22 @0x6, both re-requesting after each ack) → grants alternate 0,1,0,1 starting with port 0. No ack ever overlaps.
- Parameter sweep: READ_WAIT=4, WRITE_PULSE=3 → ram_oe_n low 5 cycles, ram_w_n low 3 cycles. Acks at T+6 and T+5.
- Reset mid-write: assert _reset while in WSTROBE → ram_w_n = 1 and ram_cs_n = 1 after the edge, no ack1, state IDLE. The RAM shows the written value.
